// File: rtl/com_bxclk_pkg.sv
// Shared state encoding and default sizing for the bx clock generator.
package com_bxclk_pkg;
   localparam int NUM_CH_DEF  = 4;
   localparam int CNT_W_DEF   = 6;
   localparam int BURST_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;
endpackage

// File: rtl/com_bxclk_phase.sv
// One delayed bx clock channel: window compare on the shared tick counter, registered.
module com_bxclk_phase #(
   parameter int CNT_W = 6
) (
   input  logic             fw_pl_clk1,
   input  logic             fw_rst,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-2:0] delay,
   input  logic [CNT_W-2:0] half,
   input  logic             sign,
   output logic             bxclk
);
   logic [CNT_W:0] lo, hi, cnt_x;
   logic           win, act;

   // One extra bit so delay + half cannot overflow.
   assign cnt_x = {1'b0, cnt};
   assign lo    = {2'b00, delay};
   assign hi    = {2'b00, delay} + {2'b00, half};
   assign win   = (cnt_x > lo) && (cnt_x <= hi);
   assign act   = (cnt != '0);

   always_ff @(posedge fw_pl_clk1) begin
      if (fw_rst) bxclk <= 1'b0;
      else        bxclk <= act && (win ^ sign);
   end
endmodule

// File: rtl/com_bxclk_gen.sv
// Bx clock generator: reference clock plus NUM_CH delayed copies, burst/stop control.
// Optional trigger output is built only with COM_BXCLK_GEN_TRIG_EN defined.
module com_bxclk_gen
   import com_bxclk_pkg::*;
#(
   parameter int NUM_CH  = NUM_CH_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BURST_W = BURST_W_DEF
) (
   input  logic                          fw_pl_clk1,
   input  logic                          fw_rst,
   input  logic [CNT_W-1:0]              cfg_period,
   input  logic [NUM_CH-1:0][CNT_W-2:0]  cfg_delay,
   input  logic [NUM_CH-1:0]             cfg_sign,
   input  logic [BURST_W-1:0]            cfg_burst_len,
   input  logic [CNT_W-1:0]              cfg_trig_pos,
   input  logic                          start,
   input  logic                          stop,
   output logic                          busy,
   output logic                          done,
   output logic                          cfg_err,
   output logic                          bxclk_ana,
   output logic [NUM_CH-1:0]             bxclk,
   output logic                          trig_out,
   output logic [BURST_W-1:0]            bx_count
);
   localparam int DLY_W = CNT_W - 1;

   state_t                         state, state_nxt;
   logic [CNT_W-1:0]               cnt, cnt_nxt, period_q;
   logic [DLY_W-1:0]               half_q, cfg_half;
   logic [NUM_CH-1:0][DLY_W-1:0]   delay_q, cap_delay;
   logic [NUM_CH-1:0]              sign_q;
   logic [BURST_W-1:0]             burst_q, bx_inc;
   logic                           run_st, start_ok, start_bad, wrap, last;

   assign run_st    = (state == RUN) || (state == STOPPING);
   assign start_ok  = (state == IDLE) && start && (cfg_period >= CNT_W'(2));
   assign start_bad = (state == IDLE) && start && (cfg_period <  CNT_W'(2));
   assign wrap      = run_st && (cnt == period_q);
   assign bx_inc    = bx_count + 1'b1;
   assign last      = (burst_q != '0) && (bx_inc == burst_q);
   assign cfg_half  = cfg_period[CNT_W-1:1];

   // Delays beyond half a period are clamped once, at capture.
   always_comb begin
      cap_delay = '0;
      for (int i = 0; i < NUM_CH; i++)
         cap_delay[i] = (cfg_delay[i] > cfg_half) ? cfg_half : cfg_delay[i];
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (start_ok) begin
               state_nxt = RUN;
               cnt_nxt   = CNT_W'(1);
            end
         end
         RUN, STOPPING: begin
            if (wrap) begin
               cnt_nxt = CNT_W'(1);
               // A stop landing on the last tick ends the run right here.
               if (state == STOPPING || stop || last) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
               if (state == RUN && stop) state_nxt = STOPPING;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge fw_pl_clk1) begin
      if (fw_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bx_count  <= '0;
         cfg_err   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bxclk_ana <= 1'b0;
         period_q  <= '0;
         half_q    <= '0;
         delay_q   <= '0;
         sign_q    <= '0;
         burst_q   <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         busy      <= (state_nxt != IDLE);
         done      <= run_st && (state_nxt == IDLE);
         bxclk_ana <= (cnt != '0) && (cnt <= {1'b0, half_q});
         if (start_ok) begin
            period_q <= cfg_period;
            half_q   <= cfg_half;
            delay_q  <= cap_delay;
            sign_q   <= cfg_sign;
            burst_q  <= cfg_burst_len;
            bx_count <= '0;
            cfg_err  <= 1'b0;
         end else if (start_bad) begin
            cfg_err  <= 1'b1;
         end else if (wrap && state_nxt != IDLE) begin
            bx_count <= bx_inc;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      com_bxclk_phase #(.CNT_W(CNT_W)) u_phase (
         .fw_pl_clk1 (fw_pl_clk1),
         .fw_rst     (fw_rst),
         .cnt        (cnt),
         .delay      (delay_q[g]),
         .half       (half_q),
         .sign       (sign_q[g]),
         .bxclk      (bxclk[g])
      );
   end

`ifdef COM_BXCLK_GEN_TRIG_EN
   logic [CNT_W-1:0] trig_pos_q;

   // cnt never reaches 0 or exceeds period while running, so those positions stay silent.
   always_ff @(posedge fw_pl_clk1) begin
      if (fw_rst) begin
         trig_pos_q <= '0;
         trig_out   <= 1'b0;
      end else begin
         if (start_ok) trig_pos_q <= cfg_trig_pos;
         trig_out <= run_st && (cnt == trig_pos_q) && (trig_pos_q != '0);
      end
   end
`else
   logic unused_trig;
   assign unused_trig = ^cfg_trig_pos;
   assign trig_out    = 1'b0;
`endif
endmodule

// File: tb/tb_com_bxclk_gen.sv
// Directed bench for com_bxclk_gen: waveform table per config plus control-path sequences.
module tb_com_bxclk_gen;
   logic             fw_pl_clk1 = 1'b0;
   logic             fw_rst;
   logic [5:0]       cfg_period;
   logic [3:0][4:0]  cfg_delay;
   logic [3:0]       cfg_sign;
   logic [15:0]      cfg_burst_len;
   logic [5:0]       cfg_trig_pos;
   logic             start, stop;
   logic             busy, done, cfg_err, bxclk_ana, trig_out;
   logic [3:0]       bxclk;
   logic [15:0]      bx_count;

   int n_run  = 0;
   int n_fail = 0;

   com_bxclk_gen dut (
      .fw_pl_clk1    (fw_pl_clk1),
      .fw_rst        (fw_rst),
      .cfg_period    (cfg_period),
      .cfg_delay     (cfg_delay),
      .cfg_sign      (cfg_sign),
      .cfg_burst_len (cfg_burst_len),
      .cfg_trig_pos  (cfg_trig_pos),
      .start         (start),
      .stop          (stop),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfg_err),
      .bxclk_ana     (bxclk_ana),
      .bxclk         (bxclk),
      .trig_out      (trig_out),
      .bx_count      (bx_count)
   );

   always #5 fw_pl_clk1 = ~fw_pl_clk1;

   typedef struct {
      logic [5:0]  period;
      logic [4:0]  d0;
      logic        s0;
      logic [4:0]  d1;
      logic        s1;
      logic [5:0]  tpos;
      logic [19:0] ana, bx0, bx1, trg;
      logic [15:0] bxc;
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(posedge fw_pl_clk1);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", nm, got, exp);
      end
   endtask

   task automatic do_reset();
      fw_rst = 1'b1;
      start  = 1'b0;
      stop   = 1'b0;
      step();
      step();
      fw_rst = 1'b0;
   endtask

   initial begin
      logic [19:0] g_ana, g_b0, g_b1, g_trg, e_trg;
      logic [13:0] g_busy, g_done, g_a14;
      int busy_cnt, done_cnt, done_at;
      logic [15:0] bx_max;
      logic done_or;

      // Samples run from the second RUN cycle for 20 ticks; MSB is the first sample.
      vecs[0] = '{6'd10, 5'd2, 1'b0, 5'd2, 1'b1, 6'd4,
                  20'b11111000001111100000, 20'b00111110000011111000,
                  20'b11000001111100000111, 20'b00010000000001000000, 16'd2};
      vecs[1] = '{6'd10, 5'd9, 1'b0, 5'd0, 1'b1, 6'd10,
                  20'b11111000001111100000, 20'b00000111110000011111,
                  20'b00000111110000011111, 20'b00000000010000000001, 16'd2};
      vecs[2] = '{6'd7, 5'd1, 1'b0, 5'd3, 1'b1, 6'd0,
                  20'b11100001110000111000, 20'b01110000111000011100,
                  20'b11100011110001111000, 20'b00000000000000000000, 16'd2};
      vecs[3] = '{6'd2, 5'd1, 1'b0, 5'd1, 1'b1, 6'd3,
                  20'b10101010101010101010, 20'b01010101010101010101,
                  20'b10101010101010101010, 20'b00000000000000000000, 16'd10};
      vecs[4] = '{6'd5, 5'd7, 1'b0, 5'd2, 1'b0, 6'd5,
                  20'b11000110001100011000, 20'b00110001100011000110,
                  20'b00110001100011000110, 20'b00001000010000100001, 16'd4};

      // Reset state, with inverted polarity configured on every channel.
      fw_rst = 1'b1; start = 1'b0; stop = 1'b0;
      cfg_period = 6'd10; cfg_delay = '0; cfg_sign = 4'hF;
      cfg_burst_len = '0; cfg_trig_pos = 6'd4;
      step(); step();
      chk("reset ctl", {busy, done, cfg_err}, 3'b000);
      chk("reset clk", {bxclk_ana, bxclk, trig_out}, 6'b0);
      chk("reset bx_count", bx_count, 16'd0);
      fw_rst = 1'b0;
      step(); step(); step();
      chk("idle sign1 clk", {bxclk_ana, bxclk, trig_out}, 6'b0);

      for (int r = 0; r < 5; r++) begin
         do_reset();
         cfg_period   = vecs[r].period;
         cfg_delay    = '0;
         cfg_delay[0] = vecs[r].d0;
         cfg_delay[1] = vecs[r].d1;
         cfg_sign     = {2'b00, vecs[r].s1, vecs[r].s0};
         cfg_burst_len = '0;
         cfg_trig_pos = vecs[r].tpos;
         start = 1'b1;
         step();
         start = 1'b0;
         g_ana = '0; g_b0 = '0; g_b1 = '0; g_trg = '0;
         for (int n = 0; n < 20; n++) begin
            step();
            g_ana = {g_ana[18:0], bxclk_ana};
            g_b0  = {g_b0[18:0], bxclk[0]};
            g_b1  = {g_b1[18:0], bxclk[1]};
            g_trg = {g_trg[18:0], trig_out};
         end
`ifdef COM_BXCLK_GEN_TRIG_EN
         e_trg = vecs[r].trg;
`else
         e_trg = '0;
`endif
         chk($sformatf("v%0d ana", r), g_ana, vecs[r].ana);
         chk($sformatf("v%0d bx0", r), g_b0, vecs[r].bx0);
         chk($sformatf("v%0d bx1", r), g_b1, vecs[r].bx1);
         chk($sformatf("v%0d trig", r), g_trg, e_trg);
         chk($sformatf("v%0d bx_count", r), bx_count, vecs[r].bxc);
         chk($sformatf("v%0d busy", r), busy, 1'b1);
      end

      // Burst of 3 periods of 8 ticks.
      do_reset();
      cfg_period = 6'd8; cfg_delay = '0; cfg_delay[0] = 5'd2; cfg_sign = 4'b0010;
      cfg_burst_len = 16'd3; cfg_trig_pos = 6'd3;
      start = 1'b1;
      busy_cnt = 0; done_cnt = 0; done_at = 0; bx_max = '0;
      for (int n = 1; n <= 40; n++) begin
         step();
         start = 1'b0;
         busy_cnt += int'(busy);
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = n;
         end
         if (bx_count > bx_max) bx_max = bx_count;
      end
      chk("burst busy cycles", busy_cnt, 24);
      chk("burst done count", done_cnt, 1);
      chk("burst done cycle", done_at, 25);
      chk("burst bx_count max", bx_max, 16'd2);
      chk("burst outputs after", {busy, bxclk_ana, bxclk, trig_out}, 7'b0);

      // Graceful stop at cnt=3 with a live period change that must be ignored.
      do_reset();
      cfg_period = 6'd10; cfg_delay = '0; cfg_sign = '0; cfg_burst_len = '0;
      start = 1'b1;
      g_busy = '0; g_done = '0; g_a14 = '0;
      for (int n = 1; n <= 14; n++) begin
         step();
         start = 1'b0;
         g_busy = {g_busy[12:0], busy};
         g_done = {g_done[12:0], done};
         g_a14  = {g_a14[12:0], bxclk_ana};
         if (n == 1) cfg_period = 6'd4;
         stop = (n == 3);
      end
      chk("stop busy", g_busy, 14'b11111111110000);
      chk("stop done", g_done, 14'b00000000001000);
      chk("stop ana", g_a14, 14'b01111100000000);
      chk("stop bx_count", bx_count, 16'd0);

      // Rejected start, then an accepted one, then reset mid-run together with start.
      do_reset();
      cfg_period = 6'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("reject busy", busy, 1'b0);
      chk("reject cfg_err", cfg_err, 1'b1);
      done_or = done;
      step(); done_or |= done;
      step(); done_or |= done;
      chk("reject no done", done_or, 1'b0);
      chk("reject sticky", cfg_err, 1'b1);
      cfg_period = 6'd10;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("accept clears err", {cfg_err, busy}, 2'b01);
      step(); step(); step(); step();
      chk("pre-reset ana", bxclk_ana, 1'b1);
      fw_rst = 1'b1;
      start  = 1'b1;
      step();
      chk("rst mid-run outs", {busy, done, cfg_err, bxclk_ana, bxclk, trig_out}, 9'b0);
      chk("rst mid-run bx_count", bx_count, 16'd0);
      fw_rst = 1'b0;
      start  = 1'b0;
      step();
      chk("rst beats start", busy, 1'b0);

      // Stop in IDLE is ignored; start+stop starts; start while busy is ignored.
      do_reset();
      cfg_period = 6'd10;
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("idle stop ignored", busy, 1'b0);
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk("start+stop runs", busy, 1'b1);
      for (int n = 2; n <= 15; n++) step();
      chk("start+stop no stopping", {busy, bx_count}, {1'b1, 16'd1});
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("busy start ignored", {busy, bx_count}, {1'b1, 16'd1});

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
